spi_status_ctrl: RTL and testbench

//  Parametrised SPI status/interrupt unit; successor to the fixed 8-bit status combiner.

---
 rtl/spi_status_ctrl_pkg.sv | 13 +
 rtl/spi_sat_counter.sv | 23 ++
 rtl/spi_status_ctrl.sv | 90 +++++++++
 tb/tb_spi_status_ctrl.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/spi_status_ctrl_pkg.sv
// spi_pkg: STATUS bit map and sticky-bit mask shared by the SPI status unit.
package spi_pkg;
    localparam int STATUS_W    = 8;
    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_FULL  = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_TX_LOW   = 4;
    localparam int ST_RX_HIGH  = 5;
    localparam int ST_RX_OVR   = 6;
    localparam int ST_RX_UDR   = 7;
    localparam logic [STATUS_W-1:0] STICKY_MASK = 8'hC8;
endpackage

// File: rtl/spi_sat_counter.sv
// spi_sat_counter: event counter that saturates at all-ones; a same-cycle clear and event yield 1.
module spi_sat_counter #(
    parameter int W = 8
) (
    input  logic         S_CLK,
    input  logic         CLR,
    input  logic         INC,
    input  logic         SCLR,
    output logic [W-1:0] CNT
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = SCLR ? W'(INC) : ((INC && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q);
    end

    always_ff @(posedge S_CLK) begin
        if (CLR) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign CNT = cnt_q;
endmodule

// File: rtl/spi_status_ctrl.sv
// spi_status_ctrl: registered SPI status word with live FIFO flags, watermarks,
// W1C sticky errors, maskable level/pulse IRQ and saturating error counters.
module spi_status_ctrl
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 8,
    parameter int IRQ_PULSE  = 0,
    localparam int LW        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                S_CLK,
    input  logic                CLR,
    input  logic [LW-1:0]       TX_LEVEL,
    input  logic [LW-1:0]       RX_LEVEL,
    input  logic [LW-1:0]       TX_WM,
    input  logic [LW-1:0]       RX_WM,
    input  logic                SENDER_WRITE,
    input  logic                RECEIVER_READ,
    input  logic                RX_PUSH,
    input  logic                STATUS_WR,
    input  logic [STATUS_W-1:0] STATUS_WDATA,
    input  logic [STATUS_W-1:0] IRQ_EN,
    input  logic                CNT_CLR,
    output logic [STATUS_W-1:0] STATUS,
    output logic                IRQ,
    output logic [CNT_W-1:0]    TX_OVF_CNT,
    output logic [CNT_W-1:0]    RX_OVR_CNT
);
    localparam logic [LW-1:0] FULL = LW'(FIFO_DEPTH);

    logic [LW-1:0]       tx_lvl, rx_lvl;
    logic                tx_ovf_ev, rx_ovr_ev, rx_udr_ev;
    logic [STATUS_W-1:0] live, set, w1c, cause;
    logic [STATUS_W-1:0] status_d, status_q, cause_prev_q;
    logic                irq_d, irq_q;

    always_comb begin
        // Out-of-range levels read as full so a misbehaving FIFO still raises flags.
        tx_lvl    = (TX_LEVEL > FULL) ? FULL : TX_LEVEL;
        rx_lvl    = (RX_LEVEL > FULL) ? FULL : RX_LEVEL;
        tx_ovf_ev = SENDER_WRITE && tx_lvl == FULL;
        rx_ovr_ev = RX_PUSH && rx_lvl == FULL;
        rx_udr_ev = RECEIVER_READ && rx_lvl == '0;
        live = '0;
        live[ST_TX_EMPTY] = tx_lvl == '0;
        live[ST_TX_FULL]  = tx_lvl == FULL;
        live[ST_RX_FULL]  = rx_lvl == FULL;
        live[ST_TX_LOW]   = tx_lvl <= TX_WM;
        live[ST_RX_HIGH]  = rx_lvl >= RX_WM;
        set = '0;
        set[ST_TX_OVF] = tx_ovf_ev;
        set[ST_RX_OVR] = rx_ovr_ev;
        set[ST_RX_UDR] = rx_udr_ev;
        w1c      = STATUS_WR ? (STATUS_WDATA & STICKY_MASK) : '0;
        status_d = live | set | (status_q & STICKY_MASK & ~w1c);
        cause    = status_q & IRQ_EN;
        irq_d    = (IRQ_PULSE != 0) ? |(cause & ~cause_prev_q) : |cause;
    end

    always_ff @(posedge S_CLK) begin
        if (CLR) begin
            status_q     <= '0;
            irq_q        <= 1'b0;
            cause_prev_q <= '0;
        end else begin
            status_q     <= status_d;
            irq_q        <= irq_d;
            cause_prev_q <= cause;
        end
    end

    spi_sat_counter #(.W(CNT_W)) u_tx_cnt (
        .S_CLK (S_CLK),
        .CLR   (CLR),
        .INC   (tx_ovf_ev),
        .SCLR  (CNT_CLR),
        .CNT   (TX_OVF_CNT)
    );

    spi_sat_counter #(.W(CNT_W)) u_rx_cnt (
        .S_CLK (S_CLK),
        .CLR   (CLR),
        .INC   (rx_ovr_ev),
        .SCLR  (CNT_CLR),
        .CNT   (RX_OVR_CNT)
    );

    assign STATUS = status_q;
    assign IRQ    = irq_q;
endmodule

// File: tb/tb_spi_status_ctrl.sv
// tb_spi_status_ctrl: directed scoreboard bench; a default instance plus a
// CNT_W=2 / IRQ_PULSE=1 instance sharing the same stimulus.
module tb_spi_status_ctrl;
    logic       clk = 1'b0;
    logic       clr;
    logic [4:0] tx_level, rx_level, tx_wm, rx_wm;
    logic       sender_write, receiver_read, rx_push, status_wr, cnt_clr;
    logic [7:0] status_wdata, irq_en;
    logic [7:0] st0, st1;
    logic       irq0, irq1;
    logic [7:0] tc0, rc0;
    logic [1:0] tc1, rc1;

    logic [31:0] exp_q[$];
    string       tag_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk = ~clk;

    spi_status_ctrl #(.FIFO_DEPTH(16), .CNT_W(8), .IRQ_PULSE(0)) dut0 (
        .S_CLK(clk), .CLR(clr), .TX_LEVEL(tx_level), .RX_LEVEL(rx_level),
        .TX_WM(tx_wm), .RX_WM(rx_wm), .SENDER_WRITE(sender_write),
        .RECEIVER_READ(receiver_read), .RX_PUSH(rx_push), .STATUS_WR(status_wr),
        .STATUS_WDATA(status_wdata), .IRQ_EN(irq_en), .CNT_CLR(cnt_clr),
        .STATUS(st0), .IRQ(irq0), .TX_OVF_CNT(tc0), .RX_OVR_CNT(rc0)
    );

    spi_status_ctrl #(.FIFO_DEPTH(16), .CNT_W(2), .IRQ_PULSE(1)) dut1 (
        .S_CLK(clk), .CLR(clr), .TX_LEVEL(tx_level), .RX_LEVEL(rx_level),
        .TX_WM(tx_wm), .RX_WM(rx_wm), .SENDER_WRITE(sender_write),
        .RECEIVER_READ(receiver_read), .RX_PUSH(rx_push), .STATUS_WR(status_wr),
        .STATUS_WDATA(status_wdata), .IRQ_EN(irq_en), .CNT_CLR(cnt_clr),
        .STATUS(st1), .IRQ(irq1), .TX_OVF_CNT(tc1), .RX_OVR_CNT(rc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input string t, input logic [31:0] v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic chk(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        n_assert++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
        end else begin
            t = tag_q.pop_front();
            e = exp_q.pop_front();
            assert (obs === e) else begin
                n_fail++;
                $error("FAIL %s: observed %0h expected %0h", t, obs, e);
            end
        end
    endtask

    initial begin
        clr = 1'b1; tx_level = '0; rx_level = '0; tx_wm = '0; rx_wm = 5'd8;
        sender_write = 0; receiver_read = 0; rx_push = 0; status_wr = 0;
        cnt_clr = 0; status_wdata = '0; irq_en = '0;
        tick(); tick();
        push_exp("reset_status", 8'h00); push_exp("reset_irq", 0);
        push_exp("reset_txcnt", 0); push_exp("reset_rxcnt", 0);
        chk(st0); chk(irq0); chk(tc0); chk(rc0);

        clr = 0;
        push_exp("idle_status", 8'h11); push_exp("idle_irq", 0);
        tick(); chk(st0); chk(irq0);

        tx_level = 5'd16; sender_write = 1;
        tick(); tick(); tick();
        push_exp("txovf_status", 8'h0A); push_exp("txovf_cnt", 3); push_exp("txovf_cnt_sat2", 3);
        chk(st0); chk(tc0); chk(tc1);
        sender_write = 0; status_wr = 1; status_wdata = 8'h08;
        push_exp("txovf_w1c", 8'h02);
        tick(); chk(st0);

        tx_level = 5'd5; rx_level = 5'd16; rx_push = 1; status_wdata = 8'h40;
        push_exp("rxovr_set_wins", 8'h64); push_exp("rxovr_cnt", 1);
        tick(); chk(st0); chk(rc0);
        rx_push = 0;
        push_exp("rxovr_w1c", 8'h24); push_exp("rxovr_cnt_hold", 1);
        tick(); chk(st0); chk(rc0);
        status_wr = 0;

        rx_push = 1;
        repeat (5) tick();
        push_exp("rxcnt_sat", 3); push_exp("rxcnt_wide", 6);
        chk(rc1); chk(rc0);
        rx_push = 0; cnt_clr = 1;
        push_exp("cntclr_rx_sat", 0); push_exp("cntclr_rx", 0); push_exp("cntclr_tx", 0);
        tick(); chk(rc1); chk(rc0); chk(tc0);
        rx_push = 1;
        push_exp("cntclr_event", 1); push_exp("cntclr_event_sat", 1);
        tick(); chk(rc0); chk(rc1);
        rx_push = 0; cnt_clr = 0; status_wr = 1; status_wdata = 8'hFF;
        push_exp("w1c_live_ignored", 8'h24);
        tick(); chk(st0);
        status_wr = 0;

        rx_level = 5'd0; irq_en = 8'h80; receiver_read = 1;
        push_exp("udr_status", 8'h80); push_exp("pulse_e1", 0);
        tick(); chk(st0); chk(irq1);
        receiver_read = 0;
        push_exp("pulse_e2", 1); push_exp("level_e2", 1);
        tick(); chk(irq1); chk(irq0);
        push_exp("pulse_e3", 0); push_exp("level_e3", 1);
        tick(); chk(irq1); chk(irq0);
        irq_en = 8'h00;
        push_exp("mask_pulse", 0); push_exp("mask_level", 0);
        tick(); chk(irq1); chk(irq0);
        irq_en = 8'h80;
        push_exp("enable_edge", 1);
        tick(); chk(irq1);
        push_exp("enable_edge_end", 0);
        tick(); chk(irq1);

        tx_level = 5'd16; sender_write = 1; rx_level = 5'd16; rx_push = 1;
        tick();
        tx_level = 5'd5; rx_level = 5'd0; sender_write = 0; rx_push = 0; receiver_read = 1;
        tick();
        receiver_read = 0;
        push_exp("pre_clr_status", 8'hC8); push_exp("pre_clr_tx", 1);
        push_exp("pre_clr_rx", 2); push_exp("pre_clr_irq", 1);
        tick(); chk(st0); chk(tc0); chk(rc0); chk(irq0);
        clr = 1; rx_level = 5'd20;
        push_exp("clr_status", 8'h00); push_exp("clr_irq", 0);
        push_exp("clr_tx", 0); push_exp("clr_rx", 0);
        tick(); chk(st0); chk(irq0); chk(tc0); chk(rc0);
        clr = 0;
        push_exp("post_clr_clamp", 8'h24);
        tick(); chk(st0);

        tx_level = 5'd20; sender_write = 1;
        push_exp("tx_clamp", 8'h2E); push_exp("tx_clamp_cnt", 1);
        tick(); chk(st0); chk(tc0);
        sender_write = 0; tx_wm = 5'd4; tx_level = 5'd4; rx_level = 5'd7;
        push_exp("tx_wm_eq", 8'h18);
        tick(); chk(st0);
        tx_level = 5'd5; rx_level = 5'd8;
        push_exp("wm_boundary", 8'h28);
        tick(); chk(st0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
